// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl -- iterative AES encryption round controller.
//
// Accepts one 128-bit plaintext block, applies the initial AddRoundKey,
// then steps an external round datapath NR times (one round per clock)
// and holds the ciphertext until the consumer takes it. The key schedule
// and the round datapath live outside this block and are both
// combinational in the cycle they are addressed.
//
// Parameters:
//   NR         number of cipher rounds after the initial AddRoundKey (1..15)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      (only with AES_CTRL_FLUSH_EN) abandon any block, back to IDLE
//   in_valid   plaintext offered            in_ready   controller idle
//   in_block   plaintext block
//   rk_idx     round-key index to key sched rk         round key for rk_idx
//   dp_block   state into round datapath    dp_final   last round (no MixColumns)
//   dp_result  round datapath output
//   out_valid  ciphertext held              out_ready  consumer takes it
//   out_block  ciphertext (always the state register)
//   busy       controller not idle
//
// Build option: define AES_CTRL_FLUSH_EN to add the flush input.

module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_CTRL_FLUSH_EN
  input  logic         flush,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] dp_block,
  output logic         dp_final,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   rnd;
  logic [127:0] st;

  // rnd is held at 0 whenever the controller is idle, so it doubles as the
  // key-schedule index in every state without extra muxing.
  assign rk_idx    = rnd;
  assign dp_block  = st;
  assign out_block = st;

  // Status flags are registered alongside the state so every output comes
  // straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rnd       <= 4'd0;
      st        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      dp_final  <= 1'b0;
    end else begin
`ifdef AES_CTRL_FLUSH_EN
      if (flush) begin
        state     <= IDLE;
        rnd       <= 4'd0;
        st        <= '0;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        dp_final  <= 1'b0;
      end else begin
`else
      begin
`endif
        case (state)
          IDLE: begin
            if (in_valid) begin
              // Initial AddRoundKey uses round key 0, addressed while idle.
              st       <= in_block ^ rk;
              rnd      <= 4'd1;
              state    <= ROUND;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              dp_final <= (NR_L == 4'd1);
            end
          end

          ROUND: begin
            st <= dp_result;
            if (rnd == NR_L) begin
              // rnd stays at NR through DONE; it is cleared on the way out.
              state     <= DONE;
              out_valid <= 1'b1;
              dp_final  <= 1'b0;
            end else begin
              rnd      <= rnd + 4'd1;
              dp_final <= ((rnd + 4'd1) == NR_L);
            end
          end

          DONE: begin
            if (out_ready) begin
              state     <= IDLE;
              rnd       <= 4'd0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end
          end

          default: begin
            state     <= IDLE;
            rnd       <= 4'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            dp_final  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl -- directed bench for aes_round_ctrl (NR = 10).
// Supplies an AES-128 key schedule on rk and a full round datapath on
// dp_result, and checks against FIPS-197 App. B / App. C.1 ciphertexts.
// Define AES_CTRL_FLUSH_EN for both files to exercise the flush input.

module tb_aes_round_ctrl;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] dp_block;
  logic         dp_final;
  logic [127:0] dp_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;
  logic         key_sel;   // 0: App. B key, 1: App. C.1 key
`ifdef AES_CTRL_FLUSH_EN
  logic         flush;
`endif

  int n_tot;
  int n_bad;

  aes_round_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef AES_CTRL_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .dp_block  (dp_block),
    .dp_final  (dp_final),
    .dp_result (dp_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES-128 reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input logic [3:0] idx);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    int          k;
    w[0] = key[127:96];
    w[1] = key[95:64];
    w[2] = key[63:32];
    w[3] = key[31:0];
    rc   = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    k = int'(idx);
    if (k > 10) return '0;
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin,
                                             input logic [127:0] k);
    logic [7:0]   b [16];
    logic [7:0]   n [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        n[r+4*c] = b[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = n[4*c];
        a1 = n[4*c+1];
        a2 = n[4*c+2];
        a3 = n[4*c+3];
        n[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
        n[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
        n[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
        n[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = n[i];
    return o ^ k;
  endfunction

  assign rk        = round_key(key_sel ? KEY_C : KEY_B, rk_idx);
  assign dp_result = aes_round(dp_block, dp_final, rk);

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_in_ready"},  128'(in_ready),  128'd1);
    chk({pfx, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({pfx, "_busy"},      128'(busy),      128'd0);
    chk({pfx, "_dp_final"},  128'(dp_final),  128'd0);
    chk({pfx, "_rk_idx"},    128'(rk_idx),    128'd0);
    chk({pfx, "_out_block"}, out_block,       128'd0);
  endtask

  // Accept one block from IDLE, wait (bounded) for the result, check, drain.
  task automatic run_block(input string tag, input logic ks,
                           input logic [127:0] pt, input logic [127:0] ct);
    int lat;
    key_sel   = ks;
    in_block  = pt;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'd10);
    chk({tag, "_ct"}, out_block, ct);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] res [2];
    int           acc_cyc [2];
    int           acc;
    int           nout;
    int           lat;
    int           w;
    logic         seen;

    n_tot     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    out_ready = 1'b0;
    key_sel   = 1'b0;
`ifdef AES_CTRL_FLUSH_EN
    flush     = 1'b0;
`endif

    // Reset state
    repeat (3) step();
    chk_reset_outputs("reset");

    // App. C.1, accepted on the first edge after reset release
    key_sel  = 1'b1;
    in_block = PT_C;
    in_valid = 1'b1;
    rst_n    = 1'b1;
    chk("c1_rk_idx_accept", 128'(rk_idx), 128'd0);
    step();
    in_valid = 1'b0;
    chk("c1_first_accept_busy", 128'(busy), 128'd1);
    chk("c1_in_ready_low", 128'(in_ready), 128'd0);
    for (int r = 1; r <= 10; r++) begin
      chk($sformatf("c1_rk_idx_%0d", r), 128'(rk_idx), 128'(r));
      chk($sformatf("c1_dp_final_%0d", r), 128'(dp_final), 128'(r == 10));
      chk($sformatf("c1_no_out_%0d", r), 128'(out_valid), 128'd0);
      step();
    end
    chk("c1_out_valid", 128'(out_valid), 128'd1);
    chk("c1_ct", out_block, CT_C);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("c1_idle_in_ready", 128'(in_ready), 128'd1);
    chk("c1_idle_out_valid", 128'(out_valid), 128'd0);

    // App. B with latency and 20 cycles of backpressure
    key_sel  = 1'b0;
    in_block = PT_B;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("b_latency", 128'(lat), 128'd10);
    chk("b_ct", out_block, CT_B);
    in_block = PT_C;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 1);
      step();
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_block", out_block, CT_B);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);
    chk("bp_release_busy", 128'(busy), 128'd0);

    // Back-to-back: B then C.1, in_valid and out_ready held high
    acc       = 0;
    nout      = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && nout < 2; cyc++) begin
      if (out_valid) begin
        res[nout] = out_block;
        nout++;
      end
      if (acc == 2) in_valid = 1'b0;
      if (in_ready && acc < 2) begin
        key_sel      = (acc == 1);
        in_block     = (acc == 0) ? PT_B : PT_C;
        in_valid     = 1'b1;
        acc_cyc[acc] = cyc;
        acc++;
      end
      if (nout < 2) step();
    end
    chk("b2b_count", 128'(nout), 128'd2);
    chk("b2b_ct0", res[0], CT_B);
    chk("b2b_ct1", res[1], CT_C);
    chk("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("b2b_idle", 128'(in_ready), 128'd1);

    // Asynchronous reset while rnd = 5
    key_sel  = 1'b0;
    in_block = PT_B;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    w = 0;
    while (rk_idx != 4'd5 && w < 20) begin
      step();
      w++;
    end
    chk("rst_mid_rnd", 128'(rk_idx), 128'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("rst_mid_no_out", 128'(seen), 128'd0);
    run_block("rst_next", 1'b1, PT_C, CT_C);

`ifdef AES_CTRL_FLUSH_EN
    // Flush at rnd = 3 with in_valid raised in the same cycle
    key_sel  = 1'b0;
    in_block = PT_B;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    w = 0;
    while (rk_idx != 4'd3 && w < 20) begin
      step();
      w++;
    end
    chk("fl_rnd", 128'(rk_idx), 128'd3);
    key_sel  = 1'b1;
    in_block = PT_C;
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_reset_outputs("fl");
    seen = 1'b0;
    repeat (15) begin
      step();
      if (out_valid || busy) seen = 1'b1;
    end
    chk("fl_no_out", 128'(seen), 128'd0);
    run_block("fl_next", 1'b1, PT_C, CT_C);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
